aer_event_packer: RTL

// - Downstream stage of the column arbiter. Consumes each granted pixel address (row xadd, column yadd).
// - Stamps it with a free-running timestamp and writes the packet into an internal FIFO.
// - Streams packets out over a valid/ready interface to the readout/link layer.
// - Drives arb_enable_o back to the row/column arbiters so grants pause before the FIFO overflows.
// - Also emits an end-of-group marker packet when the column arbiter releases its group.

---
 rtl/aer_event_packer_pkg.sv | 23 ++
 rtl/event_fifo.sv | 53 +++++
 rtl/aer_event_packer.sv | 98 +++++++++
 3 files changed

// File: rtl/aer_event_packer_pkg.sv
// Shared packet definitions for the AER event packer: tag encoding and default-width packet layout.
package aer_event_packer_pkg;

   localparam int unsigned ROW_W_DEF = 1;
   localparam int unsigned COL_W_DEF = 1;
   localparam int unsigned TS_W_DEF  = 16;
   localparam int unsigned PKT_W     = 2 + TS_W_DEF + ROW_W_DEF + COL_W_DEF;
   localparam int unsigned DROP_W    = 8;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_EVT  = 2'd1,
      TAG_EOG  = 2'd2
   } pkt_tag_e;

   typedef struct packed {
      pkt_tag_e               tag;
      logic [TS_W_DEF-1:0]    ts;
      logic [ROW_W_DEF-1:0]   xadd;
      logic [COL_W_DEF-1:0]   yadd;
   } pkt_t;

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers; read data is zero whenever empty.
module event_fifo #(
   parameter int unsigned WIDTH = 20,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned PTR_W = AW + 1
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PTR_W-1:0] free_cnt_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             push_ok;
   logic             pop_ok;

   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign free_cnt_o = PTR_W'(DEPTH) - (wr_ptr_q - rd_ptr_q);
   assign rdata_o    = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // A push into a full FIFO only lands when the head leaves in the same cycle.
   always_comb begin
      pop_ok   = pop_i & ~empty_o;
      push_ok  = push_i & (~full_o | pop_ok);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/aer_event_packer.sv
// Timestamps granted pixel addresses and end-of-group markers into a FIFO and throttles the arbiters.
module aer_event_packer
   import aer_event_packer_pkg::*;
#(
   parameter int unsigned Lvl_ROW_ADD = 1,
   parameter int unsigned Lvl_COL_ADD = 1,
   parameter int unsigned TS_W        = 16,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned AF_THRESH   = 2
) (
   input  logic                                        clk_i,
   input  logic                                        reset_ni,
   input  logic                                        evt_valid_i,
   input  logic [Lvl_ROW_ADD-1:0]                      xadd_i,
   input  logic [Lvl_COL_ADD-1:0]                      yadd_i,
   input  logic                                        grp_release_i,
   input  logic                                        pkt_ready_i,
   output logic                                        pkt_valid_o,
   output logic [2+TS_W+Lvl_ROW_ADD+Lvl_COL_ADD-1:0]   pkt_data_o,
   output logic                                        arb_enable_o,
   output logic                                        full_o,
   output logic                                        empty_o,
   output logic [DROP_W-1:0]                           drop_cnt_o
);

   localparam int unsigned PW    = 2 + TS_W + Lvl_ROW_ADD + Lvl_COL_ADD;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;
   localparam int unsigned FA_W  = PTR_W + 1;

   logic [TS_W-1:0]   ts_q, ts_d;
   logic              grp_release_q;
   logic              eog_pend_q, eog_pend_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   logic              arb_enable_q, arb_enable_d;

   logic              grp_edge;
   logic              eog_wr;
   logic              push_req;
   logic              push_ok;
   logic              pop;
   logic [PW-1:0]     wdata;
   logic [PTR_W-1:0]  free_cnt;
   logic [FA_W-1:0]   free_after;

   event_fifo #(
      .WIDTH (PW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .push_i     (push_req),
      .wdata_i    (wdata),
      .pop_i      (pop),
      .rdata_o    (pkt_data_o),
      .full_o     (full_o),
      .empty_o    (empty_o),
      .free_cnt_o (free_cnt)
   );

   assign pkt_valid_o  = ~empty_o;
   assign arb_enable_o = arb_enable_q;
   assign drop_cnt_o   = drop_cnt_q;

   // Event writes win; a pending marker waits for the first cycle without an event.
   always_comb begin
      ts_d       = ts_q + TS_W'(1);
      grp_edge   = grp_release_i & ~grp_release_q;
      pop        = ~empty_o & pkt_ready_i;
      eog_wr     = ~evt_valid_i & eog_pend_q;
      push_req   = evt_valid_i | eog_pend_q;
      push_ok    = push_req & (~full_o | pop);
      wdata      = evt_valid_i ? {2'(TAG_EVT), ts_q, xadd_i, yadd_i}
                               : {2'(TAG_EOG), ts_q, {Lvl_ROW_ADD{1'b0}}, {Lvl_COL_ADD{1'b0}}};
      eog_pend_d = eog_pend_q ? ~eog_wr : grp_edge;
      drop_cnt_d = drop_cnt_q;
      if (push_req && !push_ok && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
      free_after   = FA_W'(free_cnt) + FA_W'(pop) - FA_W'(push_ok);
      arb_enable_d = (32'(free_after) > AF_THRESH);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ts_q          <= '0;
         grp_release_q <= 1'b0;
         eog_pend_q    <= 1'b0;
         drop_cnt_q    <= '0;
         arb_enable_q  <= 1'b1;
      end else begin
         ts_q          <= ts_d;
         grp_release_q <= grp_release_i;
         eog_pend_q    <= eog_pend_d;
         drop_cnt_q    <= drop_cnt_d;
         arb_enable_q  <= arb_enable_d;
      end
   end

endmodule
